// File: rtl/scale_sequencer.sv
// scale_sequencer: safely reprograms the division ratio of an external clock divider.
// A new scale is only applied while the divider is held in reset, and the divider output
// is first waited low so the change never truncates a high phase of the divided clock.
module scale_sequencer #(
    parameter int WIDTH         = 8,
    parameter int DEFAULT_SCALE = 1,
    parameter int RST_CYCLES    = 2,
    parameter int GUARD_CYCLES  = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_scale,
    output logic             req_ready,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [WIDTH-1:0] cur_scale,
    input  logic             div_clk_out,
    output logic             div_nrst,
    output logic [WIDTH-1:0] div_scale
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_LOW = 2'd1;
    localparam logic [1:0] ST_HOLD_RST = 2'd2;
    localparam logic [1:0] ST_GUARD    = 2'd3;

    // Terminal counts: a phase lasting N cycles ends when the counter reads N-1.
    localparam logic [31:0] RST_LAST     = 32'(RST_CYCLES - 1);
    localparam logic [31:0] GUARD_LAST   = 32'(GUARD_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    localparam logic [WIDTH-1:0] RESET_SCALE = WIDTH'(DEFAULT_SCALE);

    logic [1:0]       state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_scale_q, pend_scale_d;
    logic [WIDTH-1:0] cur_scale_q, cur_scale_d;
    logic [WIDTH-1:0] div_scale_q, div_scale_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             notify_q, notify_d;
    logic             transfer;

    assign transfer = req_valid && (state_q == ST_IDLE);

    // Next-state logic: every state change clears the phase counter, and the divider scale
    // is only written on the edge that enters HOLD_RST so it never moves while running.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_scale_d = pend_scale_q;
        cur_scale_d  = cur_scale_q;
        div_scale_d  = div_scale_q;
        done_d       = 1'b0;
        err_d        = err_q;
        notify_d     = notify_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (transfer) begin
                    err_d = 1'b0;
                    if (req_scale == cur_scale_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_scale_d = req_scale;
                        notify_d     = 1'b1;
                        if (cur_scale_q == '0) begin
                            // A bypassed divider has no low phase to wait for.
                            state_d     = ST_HOLD_RST;
                            cur_scale_d = req_scale;
                            div_scale_d = req_scale;
                        end else begin
                            state_d = ST_WAIT_LOW;
                        end
                    end
                end
            end

            ST_WAIT_LOW: begin
                if (!div_clk_out) begin
                    state_d     = ST_HOLD_RST;
                    cnt_d       = '0;
                    cur_scale_d = pend_scale_q;
                    div_scale_d = pend_scale_q;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Divider appears stuck high: flag it but still force the load.
                    state_d     = ST_HOLD_RST;
                    cnt_d       = '0;
                    err_d       = 1'b1;
                    cur_scale_d = pend_scale_q;
                    div_scale_d = pend_scale_q;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            ST_HOLD_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    // Only loads that came from a request owe the requester a done pulse.
                    done_d   = notify_q;
                    notify_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset parks the divider in reset with the default scale loaded.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= ST_HOLD_RST;
            cnt_q        <= '0;
            pend_scale_q <= RESET_SCALE;
            cur_scale_q  <= RESET_SCALE;
            div_scale_q  <= RESET_SCALE;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            notify_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_scale_q <= pend_scale_d;
            cur_scale_q  <= cur_scale_d;
            div_scale_q  <= div_scale_d;
            done_q       <= done_d;
            err_q        <= err_d;
            notify_q     <= notify_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign div_nrst  = (state_q != ST_HOLD_RST);
    assign done      = done_q;
    assign err       = err_q;
    assign cur_scale = cur_scale_q;
    assign div_scale = div_scale_q;

endmodule
